// File: rtl/lsa_sample_conditioner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lsa_sample_conditioner                                                   |
// | Frame-averaging, hysteresis line detection and junction (node) counting  |
// | for a 3-channel line-sensor ADC.                                         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module lsa_sample_conditioner #(
  parameter int          AVG_LOG2   = 3,
  parameter logic [11:0] TH_HIGH    = 12'd2000,
  parameter logic [11:0] TH_LOW     = 12'd1500,
  parameter int          NODE_HOLD  = 4,
  parameter int          NODE_CNT_W = 4
) (
  input  logic                  clk_3125KHz,
  input  logic                  rst,
  input  logic                  sample_valid,
  input  logic [11:0]           left_value,
  input  logic [11:0]           center_value,
  input  logic [11:0]           right_value,
  input  logic                  clear_nodes,
  output logic [11:0]           left_avg,
  output logic [11:0]           center_avg,
  output logic [11:0]           right_avg,
  output logic                  avg_valid,
  output logic [2:0]            line_bits,
  output logic                  node_pulse,
  output logic [NODE_CNT_W-1:0] node_count
);

  localparam int                    c_acc_w       = 12 + AVG_LOG2;
  localparam logic [AVG_LOG2-1:0]   c_frame_last  = '1;
  localparam int                    c_hold_w      = $clog2(NODE_HOLD + 1);
  localparam logic [c_hold_w-1:0]   c_hold_target = NODE_HOLD[c_hold_w-1:0];

  typedef enum logic [0:0] {
    S_TRACK   = 1'b0,
    S_ON_NODE = 1'b1
  } state_t;

  logic [AVG_LOG2-1:0]   r_frame_cnt;
  logic                  r_avg_valid;
  logic                  w_final;
  logic [2:0][11:0]      w_raw;
  logic [2:0][11:0]      w_avg_all;
  logic [2:0]            w_line_all;

  state_t                r_state;
  state_t                w_state_next;
  logic [c_hold_w-1:0]   r_hold;
  logic [c_hold_w-1:0]   w_hold_next;
  logic [c_hold_w-1:0]   w_hold_inc;
  logic                  w_pulse_next;
  logic                  w_all_on;
  logic                  r_node_pulse;
  logic [NODE_CNT_W-1:0] r_node_count;

  assign w_final = sample_valid && (r_frame_cnt == c_frame_last);
  // Index 2 is left so the packed vector reads {left, center, right}.
  assign w_raw   = {left_value, center_value, right_value};

  always_ff @(posedge clk_3125KHz or posedge rst) begin
    if (rst) begin
      r_frame_cnt <= '0;
      r_avg_valid <= 1'b0;
    end else begin
      r_avg_valid <= w_final;
      if (sample_valid) begin
        r_frame_cnt <= w_final ? '0 : r_frame_cnt + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_chan
    logic [c_acc_w-1:0] r_acc;
    logic [c_acc_w-1:0] w_sum;
    logic [11:0]        w_avg_new;
    logic [11:0]        r_avg;
    logic               r_line;
    logic               w_line_new;

    assign w_sum     = r_acc + {{AVG_LOG2{1'b0}}, w_raw[g]};
    // Upper 12 bits of the sum are the truncated quotient by 2^AVG_LOG2.
    assign w_avg_new = w_sum[c_acc_w-1 -: 12];

    always_comb begin
      w_line_new = r_line;
      if (w_avg_new >= TH_HIGH) begin
        w_line_new = 1'b1;
      end else if (w_avg_new <= TH_LOW) begin
        w_line_new = 1'b0;
      end
    end

    always_ff @(posedge clk_3125KHz or posedge rst) begin
      if (rst) begin
        r_acc  <= '0;
        r_avg  <= '0;
        r_line <= 1'b0;
      end else if (sample_valid) begin
        if (w_final) begin
          r_acc  <= '0;
          r_avg  <= w_avg_new;
          r_line <= w_line_new;
        end else begin
          r_acc  <= w_sum;
        end
      end
    end

    assign w_avg_all[g]  = r_avg;
    assign w_line_all[g] = r_line;
  end

  assign w_all_on = (w_line_all == 3'b111);

  always_ff @(posedge clk_3125KHz or posedge rst) begin
    if (rst) begin
      r_state <= S_TRACK;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_next;
      r_hold  <= w_hold_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_hold_next  = r_hold;
    w_pulse_next = 1'b0;
    w_hold_inc   = r_hold + 1'b1;
    if (r_avg_valid) begin
      case (r_state)
        S_TRACK: begin
          if (w_all_on) begin
            if (w_hold_inc == c_hold_target) begin
              w_pulse_next = 1'b1;
              w_hold_next  = '0;
              w_state_next = S_ON_NODE;
            end else begin
              w_hold_next  = w_hold_inc;
            end
          end else begin
            w_hold_next = '0;
          end
        end
        S_ON_NODE: begin
          // Remain here for the whole junction so it is counted only once.
          if (!w_all_on) begin
            w_state_next = S_TRACK;
            w_hold_next  = '0;
          end
        end
        default: begin
          w_state_next = S_TRACK;
          w_hold_next  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_3125KHz or posedge rst) begin
    if (rst) begin
      r_node_pulse <= 1'b0;
      r_node_count <= '0;
    end else begin
      r_node_pulse <= w_pulse_next;
      if (clear_nodes) begin
        r_node_count <= '0;
      end else if (w_pulse_next) begin
        r_node_count <= r_node_count + 1'b1;
      end
    end
  end

  assign left_avg   = w_avg_all[2];
  assign center_avg = w_avg_all[1];
  assign right_avg  = w_avg_all[0];
  assign avg_valid  = r_avg_valid;
  assign line_bits  = w_line_all;
  assign node_pulse = r_node_pulse;
  assign node_count = r_node_count;

endmodule
`default_nettype wire
